// File: rtl/can_axil_master.sv
// can_axil_master: single-outstanding AXI4-Lite register access engine for the CAN controller IP.
// Optional watchdog on slave handshakes is built when CAN_AXIL_TIMEOUT_EN is defined.
module can_axil_master #(
  parameter int ADDR_W = 8
`ifdef CAN_AXIL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [31:0]       wr_data_in,
  input  logic              wr_enable_in,
  output logic              wr_done_out,
  output logic              wr_busy_out,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic              rd_enable_in,
  output logic              rd_done_out,
  output logic [31:0]       rd_data_out,
  output logic              err_out,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] aw_addr_q, ar_addr_q, pend_addr_q;
  logic [31:0] wdata_q, rd_data_q;
  logic [1:0] resp_q;
  logic aw_done_q, w_done_q, pend_q, is_rd_q;
  logic aw_ok, w_ok, start_rd, tmo;
  assign aw_ok = aw_done_q | (m_awvalid & m_awready);
  assign w_ok = w_done_q | (m_wvalid & m_wready);
  assign start_rd = (state_q == IDLE) & ~wr_enable_in & (rd_enable_in | pend_q);
`ifdef CAN_AXIL_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic active;
  assign active = state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
  assign tmo = active & (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge sys_clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= (state_q == IDLE) ? '0 : active ? cnt_q + 16'd1 : cnt_q;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge sys_clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = wr_enable_in ? WR_REQ : (rd_enable_in | pend_q) ? RD_REQ : IDLE;
      WR_REQ:  state_d = tmo ? DONE : (aw_ok & w_ok) ? WR_RESP : WR_REQ;
      WR_RESP: state_d = (m_bvalid | tmo) ? DONE : WR_RESP;
      RD_REQ:  state_d = tmo ? DONE : m_arready ? RD_RESP : RD_REQ;
      RD_RESP: state_d = (m_rvalid | tmo) ? DONE : RD_RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    m_awvalid   = (state_q == WR_REQ) & ~aw_done_q;
    m_wvalid    = (state_q == WR_REQ) & ~w_done_q;
    m_wstrb     = {4{state_q == WR_REQ}};
    m_bready    = state_q == WR_RESP;
    m_arvalid   = state_q == RD_REQ;
    m_rready    = state_q == RD_RESP;
    m_awaddr    = aw_addr_q;
    m_wdata     = wdata_q;
    m_araddr    = ar_addr_q;
    wr_busy_out = state_q inside {WR_REQ, WR_RESP};
    wr_done_out = (state_q == DONE) & ~is_rd_q;
    rd_done_out = (state_q == DONE) & is_rd_q;
    err_out     = (state_q == DONE) & (|resp_q);
    rd_data_out = rd_data_q;
  end
  // A read arriving while busy (or alongside a write) parks in the one-deep pending slot.
  always_ff @(posedge sys_clk or negedge reset_n)
    if (!reset_n) begin
      aw_addr_q   <= '0;
      ar_addr_q   <= '0;
      pend_addr_q <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      resp_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      pend_q      <= 1'b0;
      is_rd_q     <= 1'b0;
    end else begin
      if ((state_q == IDLE) & wr_enable_in) begin
        aw_addr_q <= wr_addr_in;
        wdata_q   <= wr_data_in;
      end
      if (start_rd) ar_addr_q <= rd_enable_in ? rd_addr_in : pend_addr_q;
      if (rd_enable_in & ((state_q != IDLE) | wr_enable_in)) begin
        pend_q      <= 1'b1;
        pend_addr_q <= rd_addr_in;
      end else if (start_rd) pend_q <= 1'b0;
      aw_done_q <= (state_q == WR_REQ) & aw_ok;
      w_done_q  <= (state_q == WR_REQ) & w_ok;
      if (state_q == IDLE) is_rd_q <= start_rd;
      if (tmo) resp_q <= 2'b10;
      if (tmo & is_rd_q) rd_data_q <= '1;
      if ((state_q == WR_RESP) & m_bvalid) resp_q <= m_bresp;
      if ((state_q == RD_RESP) & m_rvalid) begin
        resp_q    <= m_rresp;
        rd_data_q <= m_rdata;
      end
    end
endmodule

// File: tb/tb_can_axil_master.sv
// tb_can_axil_master: scoreboard bench for can_axil_master with a delay-programmable AXI4-Lite slave.
// Define CAN_AXIL_TIMEOUT_EN to also exercise the watchdog path.
module tb_can_axil_master;
  logic sys_clk = 0, reset_n = 0;
  logic [7:0] wr_addr_in = 0, rd_addr_in = 0;
  logic [31:0] wr_data_in = 0;
  logic wr_enable_in = 0, rd_enable_in = 0;
  logic wr_done_out, wr_busy_out, rd_done_out, err_out;
  logic [31:0] rd_data_out;
  logic [7:0] m_awaddr, m_araddr;
  logic [31:0] m_wdata;
  logic [3:0] m_wstrb;
  logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic m_awready = 0, m_wready = 0, m_bvalid = 0, m_arready = 0, m_rvalid = 0;
  logic [1:0] m_bresp = 0, m_rresp = 0;
  logic [31:0] m_rdata = 0;

  typedef struct {bit rd; logic [7:0] addr; logic [31:0] data; bit err;} txn_t;
  txn_t sb[$];
  txn_t e_mon;
  int n_cmp = 0, n_bad = 0, done_cnt = 0, exp_done = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
  bit aw_block = 0;
  logic [1:0] bresp_v = 0, rresp_v = 0;
  logic [31:0] rdata_v = 0;

  can_axil_master dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in), .wr_enable_in(wr_enable_in),
    .wr_done_out(wr_done_out), .wr_busy_out(wr_busy_out),
    .rd_addr_in(rd_addr_in), .rd_enable_in(rd_enable_in),
    .rd_done_out(rd_done_out), .rd_data_out(rd_data_out), .err_out(err_out),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit rd, input logic [7:0] a, input logic [31:0] d, input bit err);
    txn_t t;
    t.rd = rd; t.addr = a; t.data = d; t.err = err;
    sb.push_back(t);
    exp_done++;
  endtask

  task automatic issue(input bit wr, input bit rd, input logic [7:0] wa, input logic [31:0] wd, input logic [7:0] ra);
    @(negedge sys_clk);
    wr_enable_in = wr; rd_enable_in = rd; wr_addr_in = wa; wr_data_in = wd; rd_addr_in = ra;
    @(negedge sys_clk);
    wr_enable_in = 0; rd_enable_in = 0; wr_addr_in = ~wa; wr_data_in = ~wd; rd_addr_in = ~ra;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt < exp_done && n < limit) begin
      @(negedge sys_clk);
      n++;
    end
    check("done_wait", done_cnt, exp_done);
    @(negedge sys_clk);
  endtask

  // Slave: each ready rises once its valid has been seen for the programmed number of cycles.
  always @(negedge sys_clk) begin
    m_awready = m_awvalid && !aw_block && aw_c >= aw_dly;
    aw_c = m_awvalid ? aw_c + 1 : 0;
    m_wready = m_wvalid && w_c >= w_dly;
    w_c = m_wvalid ? w_c + 1 : 0;
    m_arready = m_arvalid && ar_c >= ar_dly;
    ar_c = m_arvalid ? ar_c + 1 : 0;
    m_bvalid = m_bready && b_c >= b_dly;
    m_bresp = bresp_v;
    b_c = m_bready ? b_c + 1 : 0;
    m_rvalid = m_rready && r_c >= r_dly;
    m_rresp = rresp_v;
    m_rdata = m_rvalid ? rdata_v : 32'hBAD0_BAD0;
    r_c = m_rready ? r_c + 1 : 0;
    if (sb.size() > 0) begin
      if (m_awready) check("awaddr", m_awaddr, sb[0].addr);
      if (m_wready) begin
        check("wdata", m_wdata, sb[0].data);
        check("wstrb", m_wstrb, 4'hF);
      end
      if (m_arready) check("araddr", m_araddr, sb[0].addr);
    end
  end

  always @(negedge sys_clk) if (reset_n) begin
    if (err_out && !wr_done_out && !rd_done_out) check("err_alone", err_out, 0);
    if (wr_done_out || rd_done_out) begin
      if (sb.size() == 0) check("spurious_done", {wr_done_out, rd_done_out}, 0);
      else begin
        e_mon = sb.pop_front();
        check("wr_done", wr_done_out, !e_mon.rd);
        check("rd_done", rd_done_out, e_mon.rd);
        check("err", err_out, e_mon.err);
        if (e_mon.rd) check("rd_data", rd_data_out, e_mon.data);
      end
      done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    check("rst_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    check("rst_flags", {wr_done_out, wr_busy_out, rd_done_out, err_out}, 0);
    check("rst_rdata", rd_data_out, 0);
    reset_n = 1;
    push(0, 8'h04, 32'h2, 0);
    issue(1, 0, 8'h04, 32'h2, 0);
    check("t1_awvalid", m_awvalid, 1);
    check("t1_busy", wr_busy_out, 1);
    @(negedge sys_clk);
    check("t1_bready", m_bready, 1);
    check("t1_early_done", wr_done_out, 0);
    @(negedge sys_clk);
    check("t1_done_n3", wr_done_out, 1);
    check("t1_busy_in_done", wr_busy_out, 0);
    wait_done(20);
    w_dly = 3; rdata_v = 32'h55;
    push(0, 8'h08, 32'hDEADBEEF, 0);
    push(1, 8'h2C, 32'h55, 0);
    issue(1, 0, 8'h08, 32'hDEADBEEF, 0);
    @(negedge sys_clk);
    check("t2_awvalid_drop", m_awvalid, 0);
    check("t2_wvalid_hold", m_wvalid, 1);
    wr_enable_in = 1; wr_addr_in = 8'h77; rd_enable_in = 1; rd_addr_in = 8'h2C;
    @(negedge sys_clk);
    wr_enable_in = 0; rd_enable_in = 0;
    wait_done(40);
    w_dly = 0; r_dly = 2; rdata_v = 32'h800;
    push(1, 8'h18, 32'h800, 0);
    issue(0, 1, 0, 0, 8'h18);
    wait_done(40);
    repeat (3) @(negedge sys_clk);
    check("t3_hold", rd_data_out, 32'h800);
    r_dly = 0; rdata_v = 32'h1234_5678;
    push(0, 8'h10, 32'hA5A5_0001, 0);
    push(1, 8'h24, 32'h1234_5678, 0);
    issue(1, 1, 8'h10, 32'hA5A5_0001, 8'h24);
    check("t4_ar_waits", m_arvalid, 0);
    wait_done(40);
    bresp_v = 2'b10;
    push(0, 8'h30, 32'h1, 1);
    issue(1, 0, 8'h30, 32'h1, 0);
    wait_done(20);
    bresp_v = 0;
    check("t5_hold_after_wr", rd_data_out, 32'h1234_5678);
    rresp_v = 2'b10; rdata_v = 32'hCAFE;
    push(1, 8'h34, 32'hCAFE, 1);
    issue(0, 1, 0, 0, 8'h34);
    wait_done(20);
    rresp_v = 0;
`ifdef CAN_AXIL_TIMEOUT_EN
    aw_block = 1;
    push(0, 8'h40, 32'h99, 1);
    issue(1, 0, 8'h40, 32'h99, 0);
    wait_done(1100);
    aw_block = 0;
    check("t5_tmo_valids", {m_awvalid, m_wvalid, m_bready}, 0);
`endif
    b_dly = 20;
    push(0, 8'h0C, 32'h6, 0);
    issue(1, 0, 8'h0C, 32'h6, 0);
    rd_enable_in = 1; rd_addr_in = 8'h33;
    @(negedge sys_clk);
    rd_enable_in = 0;
    check("t6_busy", wr_busy_out, 1);
    check("t6_bready", m_bready, 1);
    #2 reset_n = 0;
    #1 check("t6_valids_rst", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    check("t6_busy_rst", wr_busy_out, 0);
    sb.delete();
    exp_done = done_cnt;
    b_dly = 0;
    @(negedge sys_clk);
    reset_n = 1;
    repeat (4) begin
      @(negedge sys_clk);
      check("t6_no_pending", m_arvalid, 0);
    end
    push(0, 8'h0C, 32'h7, 0);
    issue(1, 0, 8'h0C, 32'h7, 0);
    wait_done(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
